// File: rtl/seven_seg_scanner.sv
// Multiplexed seven-segment display scanner with shadow-loaded digit data,
// per-digit blanking and frame-synchronised blinking.
module seven_seg_scanner #(
  parameter int DIGITS       = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   digit_data,
  input  logic [DIGITS-1:0]     digit_en,
  input  logic [DIGITS-1:0]     blink,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  frame
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PRE_W = $clog2(CLK_DIV);
  localparam int BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PRE_W-1:0]  PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_MAX = IDX_W'(DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_MAX = BLK_W'(BLINK_FRAMES - 1);
  localparam logic [6:0]        SEG_OFF = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  logic [PRE_W-1:0]    pres;
  logic [IDX_W-1:0]    idx;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic [4*DIGITS-1:0] sh_data;
  logic [DIGITS-1:0]   sh_en;
  logic [DIGITS-1:0]   sh_blink;

  logic                tick;
  logic                wrap;
  logic [3:0]          cur_code;
  logic                cur_en;
  logic                cur_blink;
  logic [6:0]          glyph;
  logic [6:0]          seg_next;
  logic [DIGITS-1:0]   an_next;

  function automatic logic [6:0] hex_glyph(input logic [3:0] code);
    logic [6:0] g;
    unique case (code)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Scan timing: the index moves on the last prescaler count, and a frame
  // ends when that move wraps the index back to digit 0.
  always_comb begin
    tick  = (pres == PRE_MAX);
    wrap  = tick && (idx == IDX_MAX);
    frame = wrap && !reset;
  end

  // State register: scan counters, blink phase, shadows and the output flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      pres        <= '0;
      idx         <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      sh_data     <= '0;
      sh_en       <= '0;
      sh_blink    <= '0;
      seg         <= SEG_OFF;
      an          <= AN_OFF;
    end else begin
      pres <= tick ? '0 : pres + 1'b1;
      if (tick) begin
        idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
      end
      if (wrap) begin
        if (blink_cnt == BLK_MAX) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end
      if (load) begin
        sh_data  <= digit_data;
        sh_en    <= digit_en;
        sh_blink <= blink;
      end
      seg <= seg_next;
      an  <= an_next;
    end
  end

  // Pick the shadow fields of the digit currently being scanned.
  always_comb begin
    cur_code  = 4'h0;
    cur_en    = 1'b0;
    cur_blink = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code  = sh_data[4*i +: 4];
        cur_en    = sh_en[i];
        cur_blink = sh_blink[i];
      end
    end
  end

  // Output decode: blanking wins over the glyph, then polarity is applied.
  always_comb begin
    glyph = hex_glyph(cur_code);
    if (!cur_en || (cur_blink && blink_phase)) begin
      glyph = 7'h00;
    end
    an_next = DIGITS'(1) << idx;
    if (ACTIVE_LOW != 0) begin
      seg_next = ~glyph;
      an_next  = ~an_next;
    end else begin
      seg_next = glyph;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a 4-digit active-low instance and
// a 1-digit active-high instance, both checked against an arithmetic scan model.
module tb_seven_seg_scanner;

  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int BF     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        load;
  logic [15:0] digit_data;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame;

  logic        load1;
  logic [3:0]  data1;
  logic        en1;
  logic        blink1;
  logic [6:0]  seg1;
  logic        an1;
  logic        frame1;

  int checks = 0;
  int errors = 0;

  // Reference model: cycles since reset plus the shadow contents.
  int          t;
  int          t1;
  logic [31:0] m_data;
  logic [7:0]  m_en;
  logic [7:0]  m_bl;
  logic [31:0] m1_data;
  logic [7:0]  m1_en;
  logic [6:0]  exp_seg;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg1;
  logic [7:0]  exp_an1;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  seven_seg_scanner #(.DIGITS(4), .CLK_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .load(load), .digit_data(digit_data),
    .digit_en(digit_en), .blink(blink), .seg(seg), .an(an), .frame(frame)
  );

  seven_seg_scanner #(.DIGITS(1), .CLK_DIV(4), .BLINK_FRAMES(2), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .reset(reset), .load(load1), .digit_data(data1),
    .digit_en(en1), .blink(blink1), .seg(seg1), .an(an1), .frame(frame1)
  );

  function automatic void model_out(input int tt, input logic [31:0] data,
                                    input logic [7:0] en, input logic [7:0] bl,
                                    input int digits, input int al,
                                    output logic [6:0] s, output logic [7:0] a);
    int idx;
    int ph;
    logic [3:0] code;
    idx  = (tt / DIV) % digits;
    ph   = ((tt / (DIV * digits)) / BF) % 2;
    code = data[idx*4 +: 4];
    s    = (!en[idx] || (bl[idx] && ph == 1)) ? 7'h00 : glyph_tab[code];
    a    = 8'(1) << idx;
    if (al != 0) begin
      s = ~s;
      a = ~a;
    end
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h t=%0d", tag, obs, expv, t);
      $error("[TB] check %s", tag);
    end
  endtask

  // One clock cycle: drive inputs, check frame, advance model, check outputs.
  task automatic applyStimulus(input logic rst, input logic ld, input logic [15:0] d,
                               input logic [3:0] e, input logic [3:0] b);
    reset      = rst;
    load       = ld;
    digit_data = d;
    digit_en   = e;
    blink      = b;
    #1;
    checkOutput("frame", {7'd0, frame}, {7'd0, !rst && (t % (DIV * DIGITS) == DIV * DIGITS - 1)});
    checkOutput("frame1", {7'd0, frame1}, {7'd0, !rst && (t1 % DIV == DIV - 1)});
    if (rst) begin
      t = 0; m_data = '0; m_en = '0; m_bl = '0;
      t1 = 0; m1_data = '0; m1_en = '0;
      exp_seg = 7'h7F; exp_an = 8'hFF;
      exp_seg1 = 7'h00; exp_an1 = 8'h00;
    end else begin
      model_out(t, m_data, m_en, m_bl, DIGITS, 1, exp_seg, exp_an);
      model_out(t1, m1_data, m1_en, 8'h00, 1, 0, exp_seg1, exp_an1);
      if (ld) begin
        m_data = {16'h0, d}; m_en = {4'h0, e}; m_bl = {4'h0, b};
      end
      if (load1) begin
        m1_data = {28'h0, data1}; m1_en = {7'h0, en1};
      end
      t++;
      t1++;
    end
    @(posedge clk);
    #1;
    checkOutput("seg", {1'b0, seg}, {1'b0, exp_seg});
    checkOutput("an", {4'h0, an}, {4'h0, exp_an[3:0]});
    checkOutput("seg1", {1'b0, seg1}, {1'b0, exp_seg1});
    checkOutput("an1", {7'h0, an1}, {7'h0, exp_an1[0]});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
    end
  endtask

  initial begin
    t = 0; t1 = 0;
    m_data = '0; m_en = '0; m_bl = '0; m1_data = '0; m1_en = '0;
    load1 = 1'b0; data1 = 4'h5; en1 = 1'b1; blink1 = 1'b0;
    reset = 1'b1; load = 1'b0; digit_data = '0; digit_en = '0; blink = '0;

    // Reset with a coincident load that must be ignored.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 16'h1234, 4'hF, 4'hF);
    idle(2);

    // Basic scan of 0..3, with the single-digit instance loaded to 5.
    load1 = 1'b1;
    applyStimulus(1'b0, 1'b1, 16'h3210, 4'hF, 4'h0);
    load1 = 1'b0;
    idle(40);

    // Blanked digits 1 and 3.
    applyStimulus(1'b0, 1'b1, 16'hFEDC, 4'b0101, 4'h0);
    idle(20);

    // Digit 0 blinking over several blink periods.
    applyStimulus(1'b0, 1'b1, 16'h0008, 4'hF, 4'b0001);
    idle(80);

    // Load coincident with the index advancing to digit 2.
    while (t % (DIV * DIGITS) != 2 * DIV - 1) idle(1);
    applyStimulus(1'b0, 1'b1, 16'h3A10, 4'hF, 4'h0);
    idle(6);

    // Reset in the middle of digit 2's dwell, then run blanked.
    while (t % (DIV * DIGITS) != 2 * DIV + 1) idle(1);
    applyStimulus(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    idle(20);

    // Randomized loads, resets and dwell lengths.
    for (int k = 0; k < 40; k++) begin
      int r;
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        applyStimulus(1'b1, 1'($urandom), 16'($urandom), 4'($urandom), 4'($urandom));
      end else if (r < 8) begin
        applyStimulus(1'b0, 1'b1, 16'($urandom), 4'($urandom), 4'($urandom));
      end
      idle(int'($urandom_range(1, 30)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scanner.md
SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits (1..8).
REQ-002 SHALL have parameter CLK_DIV, default 50000, clocks per digit dwell (>=2).
REQ-003 SHALL have parameter BLINK_FRAMES, default 64, full scan frames per blink half-period (>=1).
REQ-004 SHALL have parameter ACTIVE_LOW, default 1; 1 = seg and an driven active-low, 0 = active-high.
REQ-005 SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port load  input  1  strobe; captures digit_data, digit_en and blink into shadow registers.
REQ-008 SHALL have port digit_data  input  4*DIGITS  digit i code in bits [4i+3:4i], bit 4i+3 the MSB.
REQ-009 SHALL have port digit_en  input  DIGITS  1 = digit i visible, 0 = digit i blanked.
REQ-010 SHALL have port blink  input  DIGITS  1 = digit i blinks.
REQ-011 SHALL have port seg  output  7  segments, bit0=a ... bit6=g, registered.
REQ-012 SHALL have port an  output  DIGITS  one-hot digit select, bit i = digit i, registered.
REQ-013 SHALL have port frame  output  1  one-cycle pulse when the scan index wraps from DIGITS-1 to 0.

Function
REQ-014 Shadow registers SHALL load on any cycle with load=1; new values SHALL affect seg/an from the next cycle's output update; with load=0 shadows SHALL hold.
REQ-015 Prescaler SHALL count 0..CLK_DIV-1 and wrap to 0; digit index SHALL advance by 1 on the cycle the prescaler is at CLK_DIV-1, wrapping DIGITS-1 -> 0.
REQ-016 frame SHALL be 1 for exactly the cycle in which the index advances from DIGITS-1 to 0, else 0.
REQ-017 Blink counter SHALL count frame pulses 0..BLINK_FRAMES-1; at a frame pulse with the counter at BLINK_FRAMES-1 it SHALL wrap to 0 and blink_phase SHALL toggle.
REQ-018 Each cycle, an SHALL select only the current index: logical value (1<<index), inverted when ACTIVE_LOW=1.
REQ-019 Logical glyph (hex, g..a) SHALL be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-020 Logical seg SHALL be 00 when shadow digit_en[index]=0, or when shadow blink[index]=1 and blink_phase=1; otherwise the glyph of the shadow code for index.
REQ-021 seg SHALL be the logical value, bitwise inverted when ACTIVE_LOW=1.
REQ-022 seg and an SHALL be registered from the current index/shadow/phase: 1-cycle latency from index change or shadow load to outputs.
REQ-023 load coincident with an index advance SHALL present the new shadow data for the new index on the next cycle; neither event SHALL be lost.
REQ-024 DIGITS=1 SHALL keep index 0 permanently and pulse frame every CLK_DIV cycles.

Reset
REQ-025 With reset=1 at a clock edge, prescaler, index, blink counter and blink_phase SHALL clear to 0, and shadow data, enable and blink SHALL clear to 0 (all digits blanked).
REQ-026 During and on the cycle after reset, seg and an SHALL be inactive (all 1 when ACTIVE_LOW=1, all 0 otherwise) and frame=0.
REQ-027 Reset SHALL override a coincident load; reset mid-scan SHALL restart scanning at digit 0 with a full CLK_DIV dwell.

Verification (DIGITS=4, CLK_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=1 unless noted)
REQ-028 Reset, then load digit_data=16'h3210, digit_en=4'hF, blink=0 -> an cycles 1110,1101,1011,0111 with 4-cycle dwell; seg = ~3F,~06,~5B,~4F respectively; frame pulses every 16 cycles.
REQ-029 Load digit_data=16'hFEDC, digit_en=4'b0101 -> digits 1 and 3 show seg=7F while selected; digits 0 and 2 show ~39 and ~79.
REQ-030 blink=4'b0001, digit_en=4'hF, data 16'h0008 -> digit 0 shows ~7F for 2 frames, 7F (blank) for 2 frames, repeating; other digits unaffected.
REQ-031 load asserted on the same cycle the index advances to 2 with new digit 2 code=A -> next cycle an=1011, seg=~77.
REQ-032 reset asserted mid-dwell of digit 2 -> next cycle seg=7F, an=1111; after release digit 0 selected for full 4-cycle dwell, all blanked until load.
REQ-033 ACTIVE_LOW=0, DIGITS=1, data 4'h5, en=1 -> an=1 constant, seg=6D, frame pulses every 4 cycles.
